// File: rtl/cadastro_senha.sv
// Two-pass password registration: the password is typed twice on four BCD digits
// and committed only when both passes agree. Abort on arm, cancel or inactivity.
module cadastro_senha #(
  parameter int TIMEOUT = 1000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  incrementa,
  input  logic        confirma,
  input  logic        cancela,
  input  logic        sistema_armado,
  output logic [15:0] senha_gravada,
  output logic        senha_valida,
  output logic [15:0] digitos_trabalho,
  output logic [1:0]  estado,
  output logic        gravado,
  output logic        erro
);

  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    ENTRADA     = 2'd1,
    CONFIRMACAO = 2'd2
  } estado_t;

  localparam logic [15:0] LIMITE = 16'(TIMEOUT - 1);

  estado_t     r_estado;
  logic [15:0] r_trabalho;
  logic [15:0] r_primeira;
  logic [15:0] r_senha;
  logic        r_valida;
  logic        r_gravado;
  logic        r_erro;
  logic [15:0] r_inativo;

  logic [15:0] w_proximo;
  logic        w_atividade;
  logic        w_expirou;

  // Each digit advances independently; anything at 9 or above wraps to 0 so a
  // digit can never leave the BCD range.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digito
      logic [3:0] w_atual;
      assign w_atual = r_trabalho[4*gi +: 4];
      assign w_proximo[4*gi +: 4] = !incrementa[gi] ? w_atual :
                                    (w_atual >= 4'd9) ? 4'd0 : w_atual + 4'd1;
    end
  endgenerate

  assign w_atividade = (|incrementa) | confirma;
  assign w_expirou   = (r_inativo >= LIMITE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado   <= OCIOSO;
      r_trabalho <= 16'h0000;
      r_primeira <= 16'h0000;
      r_senha    <= 16'h0000;
      r_valida   <= 1'b0;
      r_gravado  <= 1'b0;
      r_erro     <= 1'b0;
      r_inativo  <= 16'h0000;
    end else begin
      r_gravado <= 1'b0;
      r_erro    <= 1'b0;
      // Validity follows the stored password one edge later.
      r_valida  <= (r_senha != 16'h0000);

      case (r_estado)
        OCIOSO: begin
          r_inativo <= 16'h0000;
          if (confirma && !sistema_armado) begin
            r_estado   <= ENTRADA;
            r_trabalho <= 16'h0000;
          end
        end

        ENTRADA, CONFIRMACAO: begin
          if (sistema_armado) begin
            r_erro     <= 1'b1;
            r_estado   <= OCIOSO;
            r_trabalho <= 16'h0000;
            r_inativo  <= 16'h0000;
          end else if (cancela) begin
            r_estado   <= OCIOSO;
            r_trabalho <= 16'h0000;
            r_inativo  <= 16'h0000;
          end else if (confirma) begin
            r_trabalho <= 16'h0000;
            r_inativo  <= 16'h0000;
            if (r_estado == ENTRADA) begin
              r_primeira <= r_trabalho;
              r_estado   <= CONFIRMACAO;
            end else begin
              r_estado <= OCIOSO;
              if (r_trabalho == r_primeira) begin
                r_senha   <= r_trabalho;
                r_gravado <= 1'b1;
              end else begin
                r_erro <= 1'b1;
              end
            end
          end else if (!w_atividade && w_expirou) begin
            r_erro     <= 1'b1;
            r_estado   <= OCIOSO;
            r_trabalho <= 16'h0000;
            r_inativo  <= 16'h0000;
          end else begin
            r_trabalho <= w_proximo;
            r_inativo  <= w_atividade ? 16'h0000 : r_inativo + 16'd1;
          end
        end

        default: begin
          r_estado   <= OCIOSO;
          r_trabalho <= 16'h0000;
          r_inativo  <= 16'h0000;
        end
      endcase
    end
  end

  assign senha_gravada    = r_senha;
  assign senha_valida     = r_valida;
  assign digitos_trabalho = r_trabalho;
  assign estado           = r_estado;
  assign gravado          = r_gravado;
  assign erro             = r_erro;

endmodule

// File: tb/tb_cadastro_senha.sv
// Bench for cadastro_senha: directed scenarios plus randomized traffic, checked
// every cycle against a decimal-arithmetic model of the registration rules.
module tb_cadastro_senha;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  incrementa = 4'h0;
  logic        confirma = 1'b0;
  logic        cancela = 1'b0;
  logic        sistema_armado = 1'b0;
  logic [15:0] senha_gravada;
  logic        senha_valida;
  logic [15:0] digitos_trabalho;
  logic [1:0]  estado;
  logic        gravado;
  logic        erro;

  cadastro_senha #(.TIMEOUT(TO)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .incrementa       (incrementa),
    .confirma         (confirma),
    .cancela          (cancela),
    .sistema_armado   (sistema_armado),
    .senha_gravada    (senha_gravada),
    .senha_valida     (senha_valida),
    .digitos_trabalho (digitos_trabalho),
    .estado           (estado),
    .gravado          (gravado),
    .erro             (erro)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Model: digits held as plain decimal numbers 0..9999, digit 3 = thousands.
  int m_state, m_work, m_first, m_pwd, m_idle;
  bit m_valid, m_grav, m_err;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic int pow10(input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return p;
  endfunction

  function automatic int bump(input int n, input int i);
    int d = (n / pow10(i)) % 10;
    return n - d * pow10(i) + ((d + 1) % 10) * pow10(i);
  endfunction

  task automatic model_reset();
    m_state = 0; m_work = 0; m_first = 0; m_pwd = 0; m_idle = 0;
    m_valid = 0; m_grav = 0; m_err = 0;
  endtask

  task automatic leave();
    m_state = 0; m_work = 0; m_idle = 0;
  endtask

  task automatic model_step(input logic [3:0] inc, input logic conf, input logic canc, input logic arm);
    bit was_set;
    was_set = (m_pwd != 0);
    m_grav = 0;
    m_err = 0;
    if (m_state == 0) begin
      m_idle = 0;
      if (conf && !arm) begin
        m_state = 1;
        m_work = 0;
      end
    end else if (arm) begin
      m_err = 1;
      leave();
    end else if (canc) begin
      leave();
    end else if (conf) begin
      if (m_state == 1) begin
        m_first = m_work;
        m_work = 0;
        m_state = 2;
        m_idle = 0;
      end else begin
        if (m_work == m_first) begin
          m_pwd = m_work;
          m_grav = 1;
        end else begin
          m_err = 1;
        end
        leave();
      end
    end else if (inc == 4'h0 && m_idle == TO - 1) begin
      m_err = 1;
      leave();
    end else begin
      for (int i = 0; i < 4; i++)
        if (inc[i]) m_work = bump(m_work, i);
      m_idle = (inc != 4'h0) ? 0 : m_idle + 1;
    end
    m_valid = was_set;
  endtask

  task automatic check_all();
    check_val("estado", 32'(estado), 32'(m_state));
    check_val("trabalho", 32'(digitos_trabalho), 32'(to_bcd(m_work)));
    check_val("senha", 32'(senha_gravada), 32'(to_bcd(m_pwd)));
    check_val("valida", 32'(senha_valida), 32'(m_valid));
    check_val("gravado", 32'(gravado), 32'(m_grav));
    check_val("erro", 32'(erro), 32'(m_err));
    check_val("exclusivo", 32'(gravado & erro), 32'd0);
  endtask

  task automatic step(input logic [3:0] inc, input logic conf, input logic canc, input logic arm);
    incrementa = inc;
    confirma = conf;
    cancela = canc;
    sistema_armado = arm;
    @(posedge clock);
    model_step(inc, conf, canc, arm);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic conf();
    step(4'h0, 1'b1, 1'b0, 1'b0);
  endtask

  // Types a decimal number as parallel incrementa pulses, one cycle per unit of the largest digit.
  task automatic enter(input int n);
    int d[4];
    int mx = 0;
    logic [3:0] inc;
    for (int i = 0; i < 4; i++) begin
      d[i] = (n / pow10(i)) % 10;
      if (d[i] > mx) mx = d[i];
    end
    for (int k = 0; k < mx; k++) begin
      for (int i = 0; i < 4; i++) inc[i] = (d[i] > k);
      step(inc, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic registrar(input int a, input int b);
    conf();
    enter(a);
    conf();
    enter(b);
    conf();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all();
    reset_n = 1'b1;

    // Nominal commit of 1904
    registrar(1904, 1904);
    check_val("nominal.gravado", 32'(gravado), 32'd1);
    check_val("nominal.senha", 32'(senha_gravada), 32'h1904);
    idle();
    check_val("nominal.valida", 32'(senha_valida), 32'd1);
    check_val("nominal.estado", 32'(estado), 32'd0);

    // Mismatch keeps the stored password
    registrar(1904, 1905);
    check_val("mismatch.erro", 32'(erro), 32'd1);
    check_val("mismatch.senha", 32'(senha_gravada), 32'h1904);
    idle();

    // Ten pulses wrap digit 0; confirma outranks a same-cycle incrementa
    conf();
    repeat (10) step(4'h1, 1'b0, 1'b0, 1'b0);
    check_val("wrap.digito0", 32'(digitos_trabalho), 32'h0000);
    step(4'h1, 1'b1, 1'b0, 1'b0);
    check_val("prio.estado", 32'(estado), 32'd2);
    check_val("prio.trabalho", 32'(digitos_trabalho), 32'h0000);
    step(4'h0, 1'b1, 1'b1, 1'b0);
    check_val("cancela.estado", 32'(estado), 32'd0);

    // Inactivity timeout: erro on the 8th edge after entry
    conf();
    repeat (TO - 1) idle();
    check_val("timeout.antes", 32'(estado), 32'd1);
    idle();
    check_val("timeout.erro", 32'(erro), 32'd1);
    check_val("timeout.estado", 32'(estado), 32'd0);
    idle();

    // Armed abort during CONFIRMACAO, then confirma ignored while armed
    conf();
    enter(12);
    conf();
    step(4'h3, 1'b1, 1'b1, 1'b1);
    check_val("armado.erro", 32'(erro), 32'd1);
    check_val("armado.estado", 32'(estado), 32'd0);
    step(4'h0, 1'b1, 1'b0, 1'b1);
    check_val("armado.ignora", 32'(estado), 32'd0);
    check_val("armado.sem_erro", 32'(erro), 32'd0);

    // Committing 0000 clears the password; validity falls one edge later
    registrar(0, 0);
    check_val("zero.gravado", 32'(gravado), 32'd1);
    check_val("zero.valida_ainda", 32'(senha_valida), 32'd1);
    idle();
    check_val("zero.valida", 32'(senha_valida), 32'd0);

    // Asynchronous reset between edges mid-CONFIRMACAO
    registrar(5821, 5821);
    conf();
    enter(37);
    conf();
    enter(3);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check_val("reset.senha", 32'(senha_gravada), 32'h0000);
    #1 reset_n = 1'b1;
    idle();

    // Random registrations, half of them matching
    for (int t = 0; t < 40; t++) begin
      int a;
      a = $urandom_range(0, 9999);
      registrar(a, ($urandom_range(0, 1) == 1) ? a : $urandom_range(0, 9999));
      idle();
    end

    // Free-running random traffic with occasional quiet bursts
    for (int t = 0; t < 2500; t++) begin
      if ($urandom_range(0, 99) < 3) begin
        repeat (TO + 2) idle();
      end else begin
        step(4'($urandom_range(0, 15) & $urandom_range(0, 15)),
             $urandom_range(0, 99) < 12,
             $urandom_range(0, 99) < 3,
             $urandom_range(0, 99) < 3);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
